// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program counter slice.
//   PC_WIDTH    default instruction address width (8 bits)
//   PC_RST_VEC  reset vector loaded into the PC while rst is high
//   next_sel_e  encoding of the next-PC source chosen each clock edge
//   pc_next_sel priority resolver: rst > ld > hold > increment
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int unsigned PC_WIDTH   = 8;
  localparam int unsigned PC_RST_VEC = 0;

  // Source of the value the PC register takes on the next edge.
  typedef enum logic [1:0] {
    NEXT_RST  = 2'd0,
    NEXT_LOAD = 2'd1,
    NEXT_HOLD = 2'd2,
    NEXT_INC  = 2'd3
  } next_sel_e;

  // Resolve the next-PC source from the control inputs.
  // Reset wins over a load, a load wins over a stall, and a stall wins
  // over the normal sequential advance.
  function automatic next_sel_e pc_next_sel(
    input logic rst,
    input logic ld,
    input logic hold
  );
    next_sel_e sel;
    sel = NEXT_INC;
    if (rst) begin
      sel = NEXT_RST;
    end else if (ld) begin
      sel = NEXT_LOAD;
    end else if (hold) begin
      sel = NEXT_HOLD;
    end
    return sel;
  endfunction

endpackage : pc_pkg

// File: rtl/pc_incrementer.sv
// ---------------------------------------------------------------------------
// pc_incrementer
// Combinational sequential-address generator: next_seq = pc + 1, wrapping
// from 2^WIDTH-1 back to 0 with no carry out.
// Ports:
//   pc        in   WIDTH  current program counter
//   next_seq  out  WIDTH  address of the next sequential instruction
// ---------------------------------------------------------------------------
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_seq
);

  // The carry out of the MSB is simply discarded, giving modulo-2^WIDTH wrap.
  always_comb begin
    next_seq = pc + WIDTH'(1);
  end

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Program counter for the single-cycle CPU. Holds the address of the current
// instruction, advances by one every clock, and loads an absolute jump/branch
// target when the control unit strobes ld.
//
// Optional feature macro: PC_HOLD_EN
//   defined   -> adds a 'hold' input (stall); priority rst > ld > hold > inc
//   undefined -> no hold port; the PC increments on every edge with ld=0
//
// Ports:
//   clk     in   1      system clock, rising-edge active
//   rst     in   1      asynchronous active-high reset, forces RST_VAL
//   ld      in   1      load strobe: take addr on the next rising edge
//   hold    in   1      (PC_HOLD_EN only) keep pc_out unchanged this edge
//   addr    in   WIDTH  jump target, sampled only when ld=1
//   pc_out  out  WIDTH  current PC, driven straight from the register
// ---------------------------------------------------------------------------
module program_counter
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH   = PC_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(PC_RST_VEC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
`ifdef PC_HOLD_EN
  input  logic             hold,
`endif
  input  logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] pc_out
);

  logic             hold_c;
  next_sel_e        next_sel;
  logic [WIDTH-1:0] next_seq;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_q;

  // Stall request; tied off when the stall feature is not built in.
`ifdef PC_HOLD_EN
  assign hold_c = hold;
`else
  assign hold_c = 1'b0;
`endif

  // Sequential next address.
  pc_incrementer #(
    .WIDTH (WIDTH)
  ) u_pc_incrementer (
    .pc       (pc_q),
    .next_seq (next_seq)
  );

  // Choose the next-PC source by priority.
  always_comb begin
    next_sel = NEXT_INC;
    next_sel = pc_next_sel(rst, ld, hold_c);
  end

  // Next-PC mux. addr only reaches the register through the LOAD arm, so an
  // unused (even X) addr can never leak into the PC.
  always_comb begin
    pc_next = next_seq;
    case (next_sel)
      NEXT_RST:  pc_next = RST_VAL;
      NEXT_LOAD: pc_next = addr;
      NEXT_HOLD: pc_next = pc_q;
      NEXT_INC:  pc_next = next_seq;
      default:   pc_next = next_seq;
    endcase
  end

  // PC register; reset acts immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RST_VAL;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc_out = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized run compared every cycle against an integer reference model.
// ---------------------------------------------------------------------------
module tb_program_counter;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         ld;
`ifdef PC_HOLD_EN
  logic         hold;
`endif
  logic [W-1:0] addr;
  logic [W-1:0] pc_out;

  int checks   = 0;
  int failures = 0;
  int model_pc = 0;
  bit cmp_en   = 1'b0;

  program_counter #(
    .WIDTH   (W),
    .RST_VAL (8'h00)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
`ifdef PC_HOLD_EN
    .hold   (hold),
`endif
    .addr   (addr),
    .pc_out (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer PC updated from the architectural rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_pc = 0;
    end else if (ld) begin
      model_pc = int'(addr);
`ifdef PC_HOLD_EN
    end else if (hold) begin
      model_pc = model_pc;
`endif
    end else begin
      model_pc = (model_pc + 1) % 256;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input int exp);
    checks++;
    if (act !== W'(exp)) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, W'(exp), $time);
    end
  endtask

  // Literal expectation: pins both the DUT and the reference model.
  task automatic lit(input string name, input int exp);
    check({name, "_dut"}, pc_out, exp);
    check({name, "_model"}, W'(model_pc), exp);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) check("cycle_cmp", pc_out, model_pc);
  end

  // Apply inputs, let one rising edge pass, settle 1 time unit after it.
  task automatic step(input logic l, input logic [W-1:0] a);
    ld   = l;
    addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    ld   = 1'b0;
    addr = 8'h00;
`ifdef PC_HOLD_EN
    hold = 1'b0;
`endif
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_powerup", pc_out, 0);

    // 1. Power-up then 10 increments
    step(1'b0, 8'h00);
    lit("reset_edge", 8'h00);
    cmp_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, W'($urandom));
    lit("ten_incs", 8'h0A);

    // 2. Jump to zero then count
    step(1'b1, 8'h00);
    lit("jump_zero", 8'h00);
    step(1'b0, 8'h00);
    lit("after_jump_1", 8'h01);
    step(1'b0, 8'h00);
    lit("after_jump_2", 8'h02);

    // 3. Jumps to new targets
    step(1'b1, 8'hA7);
    lit("jump_a7", 8'hA7);
    step(1'b0, 8'h00);
    lit("a8", 8'hA8);
    step(1'b0, 8'h00);
    lit("a9", 8'hA9);
    step(1'b1, 8'h69);
    lit("jump_69", 8'h69);
    step(1'b0, 8'h69);
    lit("6a", 8'h6A);

    // 4. Wrap-around
    step(1'b1, 8'hFE);
    lit("load_fe", 8'hFE);
    step(1'b0, 8'h00);
    lit("ff", 8'hFF);
    step(1'b0, 8'h00);
    lit("wrap_00", 8'h00);
    step(1'b0, 8'h00);
    lit("wrap_01", 8'h01);

    // 5. Async reset mid-count, then reset overriding a load
    step(1'b1, 8'h34);
    step(1'b0, 8'h00);
    lit("at_35", 8'h35);
    #1 rst = 1'b1;
    #1 lit("async_mid_cycle", 8'h00);
    step(1'b1, 8'h55);
    lit("rst_over_ld", 8'h00);
    rst = 1'b0;
    step(1'b0, 8'h55);
    lit("release_inc", 8'h01);

    // 6. addr toggling with ld=0 has no effect
    step(1'b1, 8'h20);
    step(1'b0, 8'h12);
    step(1'b0, 8'h34);
    step(1'b0, 8'h56);
    step(1'b0, 8'h78);
    lit("addr_ignored", 8'h24);

    // ld held high with a constant target
    for (int i = 0; i < 3; i++) step(1'b1, 8'h40);
    lit("ld_held", 8'h40);

`ifdef PC_HOLD_EN
    step(1'b1, 8'h10);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h99);
    lit("hold_3", 8'h10);
    hold = 1'b0;
    step(1'b0, 8'h99);
    lit("hold_release", 8'h11);
    // load beats hold
    hold = 1'b1;
    step(1'b1, 8'h77);
    lit("ld_over_hold", 8'h77);
    hold = 1'b0;
`endif

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
`ifdef PC_HOLD_EN
      hold = ($urandom_range(0, 4) == 0);
`endif
      step(($urandom_range(0, 3) == 0), W'($urandom));
    end
    rst = 1'b0;
    step(1'b0, 8'h00);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_program_counter
